// File: rtl/mmc_ctrl_pkg.sv
// Shared definitions for the MMC SPI command-layer initialisation sequencer.
// Holds the sequencer state encoding, the byte-interface grant codes, the
// idle byte value and the default dummy-byte / timeout counts.
package mmc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DUMMY      = 3'd1,
    ST_CMD0_START = 3'd2,
    ST_CMD0_WAIT  = 3'd3,
    ST_CMD1_START = 3'd4,
    ST_CMD1_WAIT  = 3'd5,
    ST_READY      = 3'd6,
    ST_ERROR      = 3'd7
  } init_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CMD0 = 2'd1,
    GNT_CMD1 = 2'd2,
    GNT_USER = 2'd3
  } grant_t;

  localparam logic [7:0]  MMC_IDLE_BYTE       = 8'hFF;
  localparam int unsigned DEFAULT_DUMMY_BYTES = 10;
  localparam logic [23:0] DEFAULT_TIMEOUT     = 24'd1000000;

endpackage

// File: rtl/mmc_byte_if_mux.sv
// Combinational arbiter between three byte sources (CMD0 block, CMD1 block,
// user path) and the MMC byte transport.
// Ports:
//   grant            selects which source drives the transport
//   idle_req         request driven to the transport when no source is granted
//   cmd0_*/cmd1_*/user_*  per-source req/cs/data in, busy back out
//   mmc_busy         transport busy in
//   mmc_req/cs/data  transport request/chip-select/byte out
// Non-granted sources always see busy=1.
module mmc_byte_if_mux
  import mmc_ctrl_pkg::*;
(
  input  grant_t     grant,
  input  logic       idle_req,
  input  logic       cmd0_req,
  input  logic       cmd0_cs,
  input  logic [7:0] cmd0_data,
  output logic       cmd0_busy,
  input  logic       cmd1_req,
  input  logic       cmd1_cs,
  input  logic [7:0] cmd1_data,
  output logic       cmd1_busy,
  input  logic       user_req,
  input  logic       user_cs,
  input  logic [7:0] user_data,
  output logic       user_busy,
  input  logic       mmc_busy,
  output logic       mmc_req,
  output logic       mmc_cs,
  output logic [7:0] mmc_data
);

  always_comb begin
    mmc_req   = idle_req;
    mmc_cs    = 1'b1;
    mmc_data  = MMC_IDLE_BYTE;
    cmd0_busy = 1'b1;
    cmd1_busy = 1'b1;
    user_busy = 1'b1;
    case (grant)
      GNT_CMD0: begin
        mmc_req   = cmd0_req;
        mmc_cs    = cmd0_cs;
        mmc_data  = cmd0_data;
        cmd0_busy = mmc_busy;
      end
      GNT_CMD1: begin
        mmc_req   = cmd1_req;
        mmc_cs    = cmd1_cs;
        mmc_data  = cmd1_data;
        cmd1_busy = mmc_busy;
      end
      GNT_USER: begin
        mmc_req   = user_req;
        mmc_cs    = user_cs;
        mmc_data  = user_data;
        user_busy = mmc_busy;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mmc_cmd_control_layer_init_seq.sv
// Power-up initialisation sequencer and byte-interface arbiter for the MMC
// SPI command layer. Sends P_DUMMY_BYTES 0xFF bytes with CS high, runs the
// CMD0 then CMD1 sub-blocks under a cycle timeout, then hands the byte
// interface to the user path.
// Ports:
//   iCLOCK, iRESET_SYNC         clock, synchronous active-high reset
//   iINIT_START                 start / restart (IDLE, READY, ERROR only)
//   oINIT_BUSY/DONE/ERROR       status levels
//   oSUB_RESET                  one-cycle sub-block reset on timeout
//   oCMDx_START, iCMDx_END      sub-block handshake
//   iCMDx_MMC_*, oCMDx_MMC_BUSY sub-block byte interface
//   iUSER_MMC_*, oUSER_MMC_BUSY user byte interface
//   oMMC_REQ/CS/DATA, iMMC_BUSY transport byte interface
module mmc_cmd_control_layer_init_seq
  import mmc_ctrl_pkg::*;
#(
  parameter int unsigned P_DUMMY_BYTES = DEFAULT_DUMMY_BYTES,
  parameter logic [23:0] P_TIMEOUT     = DEFAULT_TIMEOUT
) (
  input  logic       iCLOCK,
  input  logic       iRESET_SYNC,
  input  logic       iINIT_START,
  output logic       oINIT_BUSY,
  output logic       oINIT_DONE,
  output logic       oINIT_ERROR,
  output logic       oSUB_RESET,
  output logic       oCMD0_START,
  input  logic       iCMD0_END,
  input  logic       iCMD0_MMC_REQ,
  input  logic       iCMD0_MMC_CS,
  input  logic [7:0] iCMD0_MMC_DATA,
  output logic       oCMD0_MMC_BUSY,
  output logic       oCMD1_START,
  input  logic       iCMD1_END,
  input  logic       iCMD1_MMC_REQ,
  input  logic       iCMD1_MMC_CS,
  input  logic [7:0] iCMD1_MMC_DATA,
  output logic       oCMD1_MMC_BUSY,
  input  logic       iUSER_MMC_REQ,
  input  logic       iUSER_MMC_CS,
  input  logic [7:0] iUSER_MMC_DATA,
  output logic       oUSER_MMC_BUSY,
  output logic       oMMC_REQ,
  input  logic       iMMC_BUSY,
  output logic       oMMC_CS,
  output logic [7:0] oMMC_DATA
);

  localparam logic [7:0]  DUMMY_LAST   = 8'(P_DUMMY_BYTES - 32'd1);
  localparam logic [23:0] TIMEOUT_LAST = P_TIMEOUT - 24'd1;

  init_state_t state_q, state_d;
  logic [7:0]  dummy_cnt;
  logic [23:0] timeout_cnt;
  grant_t      grant;
  logic        idle_req;
  logic        byte_accept;
  logic        timeout_hit;

  assign byte_accept = oMMC_REQ && !iMMC_BUSY;
  assign timeout_hit = (timeout_cnt == TIMEOUT_LAST);

  // State register
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  // Counters. The dummy counter is held at zero outside DUMMY, which is
  // equivalent to clearing it on entry.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      dummy_cnt   <= '0;
      timeout_cnt <= '0;
    end else begin
      if (state_q != ST_DUMMY)
        dummy_cnt <= '0;
      else if (byte_accept)
        dummy_cnt <= dummy_cnt + 8'd1;

      if (state_q == ST_CMD0_START || state_q == ST_CMD1_START)
        timeout_cnt <= '0;
      else if (state_q == ST_CMD0_WAIT || state_q == ST_CMD1_WAIT)
        timeout_cnt <= timeout_cnt + 24'd1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (iINIT_START) state_d = ST_DUMMY;
      ST_DUMMY:      if (byte_accept && dummy_cnt == DUMMY_LAST) state_d = ST_CMD0_START;
      ST_CMD0_START: state_d = ST_CMD0_WAIT;
      ST_CMD0_WAIT: begin
        // END wins over a timeout landing on the same cycle
        if (iCMD0_END)        state_d = ST_CMD1_START;
        else if (timeout_hit) state_d = ST_ERROR;
      end
      ST_CMD1_START: state_d = ST_CMD1_WAIT;
      ST_CMD1_WAIT: begin
        if (iCMD1_END)        state_d = ST_READY;
        else if (timeout_hit) state_d = ST_ERROR;
      end
      ST_READY:      if (iINIT_START) state_d = ST_DUMMY;
      ST_ERROR:      if (iINIT_START) state_d = ST_DUMMY;
      default:       state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    oINIT_BUSY  = 1'b0;
    oINIT_DONE  = 1'b0;
    oINIT_ERROR = 1'b0;
    oSUB_RESET  = 1'b0;
    oCMD0_START = 1'b0;
    oCMD1_START = 1'b0;
    grant       = GNT_NONE;
    idle_req    = 1'b0;
    case (state_q)
      ST_DUMMY: begin
        oINIT_BUSY = 1'b1;
        idle_req   = !iMMC_BUSY;
      end
      ST_CMD0_START: begin
        oINIT_BUSY  = 1'b1;
        oCMD0_START = 1'b1;
      end
      ST_CMD0_WAIT: begin
        oINIT_BUSY = 1'b1;
        grant      = GNT_CMD0;
        oSUB_RESET = !iCMD0_END && timeout_hit;
      end
      ST_CMD1_START: begin
        oINIT_BUSY  = 1'b1;
        oCMD1_START = 1'b1;
      end
      ST_CMD1_WAIT: begin
        oINIT_BUSY = 1'b1;
        grant      = GNT_CMD1;
        oSUB_RESET = !iCMD1_END && timeout_hit;
      end
      ST_READY: begin
        oINIT_DONE = 1'b1;
        grant      = GNT_USER;
      end
      ST_ERROR: oINIT_ERROR = 1'b1;
      default: ;
    endcase
  end

  mmc_byte_if_mux u_mux (
    .grant     (grant),
    .idle_req  (idle_req),
    .cmd0_req  (iCMD0_MMC_REQ),
    .cmd0_cs   (iCMD0_MMC_CS),
    .cmd0_data (iCMD0_MMC_DATA),
    .cmd0_busy (oCMD0_MMC_BUSY),
    .cmd1_req  (iCMD1_MMC_REQ),
    .cmd1_cs   (iCMD1_MMC_CS),
    .cmd1_data (iCMD1_MMC_DATA),
    .cmd1_busy (oCMD1_MMC_BUSY),
    .user_req  (iUSER_MMC_REQ),
    .user_cs   (iUSER_MMC_CS),
    .user_data (iUSER_MMC_DATA),
    .user_busy (oUSER_MMC_BUSY),
    .mmc_busy  (iMMC_BUSY),
    .mmc_req   (oMMC_REQ),
    .mmc_cs    (oMMC_CS),
    .mmc_data  (oMMC_DATA)
  );

endmodule

// File: tb/tb_mmc_cmd_control_layer_init_seq.sv
// Self-checking bench for mmc_cmd_control_layer_init_seq with randomized
// transport busy, sub-block and user traffic.
module tb_mmc_cmd_control_layer_init_seq;

  localparam int NDUMMY = 10;
  localparam int P_TO   = 100;

  logic clk = 1'b0;
  logic rst, init_start;
  logic init_busy, init_done, init_error, sub_reset;
  logic cmd0_start, cmd0_end, cmd0_req, cmd0_cs, cmd0_busy;
  logic cmd1_start, cmd1_end, cmd1_req, cmd1_cs, cmd1_busy;
  logic [7:0] cmd0_data, cmd1_data, user_data, mmc_data;
  logic user_req, user_cs, user_busy;
  logic mmc_req, mmc_busy, mmc_cs;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mmc_cmd_control_layer_init_seq #(
    .P_DUMMY_BYTES(NDUMMY),
    .P_TIMEOUT    (24'(P_TO))
  ) dut (
    .iCLOCK        (clk),
    .iRESET_SYNC   (rst),
    .iINIT_START   (init_start),
    .oINIT_BUSY    (init_busy),
    .oINIT_DONE    (init_done),
    .oINIT_ERROR   (init_error),
    .oSUB_RESET    (sub_reset),
    .oCMD0_START   (cmd0_start),
    .iCMD0_END     (cmd0_end),
    .iCMD0_MMC_REQ (cmd0_req),
    .iCMD0_MMC_CS  (cmd0_cs),
    .iCMD0_MMC_DATA(cmd0_data),
    .oCMD0_MMC_BUSY(cmd0_busy),
    .oCMD1_START   (cmd1_start),
    .iCMD1_END     (cmd1_end),
    .iCMD1_MMC_REQ (cmd1_req),
    .iCMD1_MMC_CS  (cmd1_cs),
    .iCMD1_MMC_DATA(cmd1_data),
    .oCMD1_MMC_BUSY(cmd1_busy),
    .iUSER_MMC_REQ (user_req),
    .iUSER_MMC_CS  (user_cs),
    .iUSER_MMC_DATA(user_data),
    .oUSER_MMC_BUSY(user_busy),
    .oMMC_REQ      (mmc_req),
    .iMMC_BUSY     (mmc_busy),
    .oMMC_CS       (mmc_cs),
    .oMMC_DATA     (mmc_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_sources();
    cmd0_req  = 1'($urandom);
    cmd0_cs   = 1'($urandom);
    cmd0_data = 8'($urandom);
    cmd1_req  = 1'($urandom);
    cmd1_cs   = 1'($urandom);
    cmd1_data = 8'($urandom);
    user_req  = 1'($urandom);
    user_cs   = 1'($urandom);
    user_data = 8'($urandom);
  endtask

  // Transport must look idle and nobody may hold the grant.
  task automatic check_idle(input string tag, input logic err);
    check({tag, "_req"}, mmc_req, 0);
    check({tag, "_cs"}, mmc_cs, 1);
    check({tag, "_data"}, mmc_data, 8'hFF);
    check({tag, "_busys"}, {cmd0_busy, cmd1_busy, user_busy}, 3'b111);
    check({tag, "_starts"}, {cmd0_start, cmd1_start}, 2'b00);
    check({tag, "_status"}, {init_busy, init_done, init_error}, {2'b00, err});
    check({tag, "_subrst"}, sub_reset, 0);
  endtask

  // Caller has already requested the start; we are in the first DUMMY cycle.
  task automatic run_dummy(input int mode);
    int n = 0;
    int cyc = 0;
    int last_acc = -100;
    bit seen = 0;
    cmd0_end = 0;
    cmd1_end = 0;
    while (!seen && cyc < 200) begin
      randomize_sources();
      init_start = 1'($urandom);
      case (mode)
        0: mmc_busy = 1'b0;
        1: mmc_busy = 1'(cyc % 2);
        default: mmc_busy = 1'($urandom);
      endcase
      @(negedge clk);
      check("dummy_init_busy", init_busy, 1);
      if (cmd0_start) begin
        seen = 1;
        check("cmd0_start_latency", cyc - last_acc, 1);
        check("cmd0_start_req", mmc_req, 0);
        check("cmd0_start_no_cmd1", cmd1_start, 0);
      end else begin
        check("dummy_req", mmc_req, !mmc_busy);
        check("dummy_cs", mmc_cs, 1);
        check("dummy_data", mmc_data, 8'hFF);
        check("dummy_busys", {cmd0_busy, cmd1_busy, user_busy}, 3'b111);
        check("dummy_done_err", {init_done, init_error}, 2'b00);
        if (mmc_req && !mmc_busy) begin
          n++;
          last_acc = cyc;
        end
      end
      next_cycle();
      cyc++;
    end
    init_start = 0;
    check("dummy_start_seen", seen, 1);
    check("dummy_bytes", n, NDUMMY);
  endtask

  // One WAIT phase. which: 0=CMD0, 1=CMD1. END is raised after nbytes
  // accepted bytes, or on WAIT cycle end_at when end_at >= 0.
  task automatic wait_phase(input int which, input int nbytes, input int end_at,
                            output bit fin, output int subs);
    int acc = 0;
    int k = 0;
    logic e, sreq, scs, gbusy;
    logic [7:0] sdata;
    fin = 0;
    subs = 0;
    while (!fin && k < P_TO) begin
      randomize_sources();
      init_start = 1'($urandom);
      mmc_busy = 1'($urandom);
      e = (end_at >= 0) ? (k == end_at) : (acc >= nbytes);
      sreq = e ? 1'b0 : ($urandom % 4 != 0);
      if (which == 0) begin
        cmd0_req = sreq; cmd0_end = e; cmd1_end = 0;
        scs = cmd0_cs; sdata = cmd0_data;
      end else begin
        cmd1_req = sreq; cmd1_end = e; cmd0_end = 0;
        scs = cmd1_cs; sdata = cmd1_data;
      end
      @(negedge clk);
      gbusy = (which == 0) ? cmd0_busy : cmd1_busy;
      check("wait_req", mmc_req, sreq);
      check("wait_cs", mmc_cs, scs);
      check("wait_data", mmc_data, sdata);
      check("wait_gnt_busy", gbusy, mmc_busy);
      check("wait_other_busy", (which == 0) ? cmd1_busy : cmd0_busy, 1);
      check("wait_user_busy", user_busy, 1);
      check("wait_status", {init_busy, init_done, init_error}, 3'b100);
      check("wait_starts", {cmd0_start, cmd1_start}, 2'b00);
      check("wait_subrst", sub_reset, (k == P_TO - 1) && !e);
      if (sub_reset) subs++;
      if (mmc_req && !mmc_busy) acc++;
      fin = e;
      next_cycle();
      k++;
    end
    cmd0_end = 0;
    cmd1_end = 0;
    init_start = 0;
  endtask

  task automatic expect_cmd1_start();
    randomize_sources();
    mmc_busy = 1'($urandom);
    @(negedge clk);
    check("cmd1_start_pulse", {cmd0_start, cmd1_start}, 2'b01);
    check("cmd1_start_req", mmc_req, 0);
    check("cmd1_start_status", {init_busy, init_error}, 2'b10);
    next_cycle();
  endtask

  task automatic pulse_start();
    init_start = 1;
    @(negedge clk);
    next_cycle();
    init_start = 0;
  endtask

  bit fin;
  int subs;

  initial begin
    rst = 1; init_start = 0; mmc_busy = 0; cmd0_end = 0; cmd1_end = 0;
    randomize_sources();
    repeat (2) next_cycle();
    init_start = 1;
    @(negedge clk);
    check_idle("reset", 0);
    next_cycle();
    rst = 0; init_start = 0;
    @(negedge clk);
    check_idle("idle_hold", 0);
    next_cycle();

    // Full init, transport never busy during DUMMY
    pulse_start();
    run_dummy(0);
    wait_phase(0, 7, -1, fin, subs);
    check("cmd0_ended", fin, 1);
    expect_cmd1_start();
    wait_phase(1, 3 * 6, -1, fin, subs);
    check("cmd1_ended", fin, 1);

    // READY: user path owns the transport
    user_req = 1; user_cs = 0; user_data = 8'h51; mmc_busy = 0;
    cmd0_req = 1; cmd1_req = 1;
    @(negedge clk);
    check("ready_done", {init_busy, init_done, init_error}, 3'b010);
    check("ready_user_req", mmc_req, 1);
    check("ready_user_cs", mmc_cs, 0);
    check("ready_user_data", mmc_data, 8'h51);
    check("ready_cmd_busys", {cmd0_busy, cmd1_busy}, 2'b11);
    check("ready_user_busy", user_busy, 0);
    next_cycle();
    for (int i = 0; i < 8; i++) begin
      randomize_sources();
      mmc_busy = 1'($urandom);
      init_start = (i == 7);
      @(negedge clk);
      check("ready_pass_req", mmc_req, user_req);
      check("ready_pass_cs", mmc_cs, user_cs);
      check("ready_pass_data", mmc_data, user_data);
      check("ready_pass_busy", user_busy, mmc_busy);
      check("ready_pass_cmd1_busy", cmd1_busy, 1);
      next_cycle();
    end
    init_start = 0;

    // Re-init with toggling busy, then CMD1 never ends -> timeout
    run_dummy(1);
    wait_phase(0, 3, -1, fin, subs);
    check("reinit_cmd0_ended", fin, 1);
    expect_cmd1_start();
    wait_phase(1, 100000, -1, fin, subs);
    check("timeout_no_end", fin, 0);
    check("timeout_subrst_count", subs, 1);
    for (int i = 0; i < 3; i++) begin
      randomize_sources();
      mmc_busy = 1'($urandom);
      @(negedge clk);
      check_idle("error", 1);
      next_cycle();
    end

    // END on the timeout cycle takes priority
    pulse_start();
    run_dummy(2);
    wait_phase(0, 100000, P_TO - 1, fin, subs);
    check("prio_end_taken", fin, 1);
    check("prio_no_subrst", subs, 0);
    expect_cmd1_start();

    // Reset while in CMD0_WAIT
    rst = 1;
    @(negedge clk);
    next_cycle();
    rst = 0;
    pulse_start();
    run_dummy(2);
    rst = 1; cmd0_req = 1; mmc_busy = 0;
    @(negedge clk);
    check("rst_in_wait_subrst", sub_reset, 0);
    next_cycle();
    rst = 0;
    @(negedge clk);
    check_idle("after_reset", 0);
    next_cycle();
    pulse_start();
    run_dummy(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mmc_cmd_control_layer_init_seq.md
Name: mmc_cmd_control_layer_init_seq

Overview:
- Power-up initialisation sequencer and byte-interface arbiter for the MMC SPI command layer.
- Sends dummy 0xFF bytes with CS deasserted, then runs the CMD0 sub-block, then the CMD1 sub-block, each under a cycle timeout.
- After initialisation completes, hands the byte interface to the user-side command path.
- Sits between the command sub-blocks / user path and the MMC byte transport.

Parameters:
- P_DUMMY_BYTES, 10, number of 0xFF bytes sent with CS high (10 bytes = 80 SPI clocks).
- P_TIMEOUT, 24'd1000000, maximum cycles spent in either CMD wait state before abort.

Ports:
- iCLOCK  in  1  clock.
- iRESET_SYNC  in  1  reset: synchronous, active-high.
- iINIT_START  in  1  start or restart initialisation; sampled in IDLE, READY and ERROR.
- oINIT_BUSY  out  1  high from DUMMY through CMD1_WAIT.
- oINIT_DONE  out  1  level, high in READY.
- oINIT_ERROR  out  1  level, high in ERROR.
- oSUB_RESET  out  1  one-cycle pulse to the sub-blocks' iRESET_SYNC on timeout.
- oCMD0_START  out  1  one-cycle start pulse to the CMD0 block.
- iCMD0_END  in  1  CMD0 completion.
- iCMD0_MMC_REQ / iCMD0_MMC_CS / iCMD0_MMC_DATA  in  1/1/8  CMD0 byte request.
- oCMD0_MMC_BUSY  out  1  busy returned to the CMD0 block.
- oCMD1_START, iCMD1_END, iCMD1_MMC_REQ, iCMD1_MMC_CS, iCMD1_MMC_DATA, oCMD1_MMC_BUSY  same widths, for the CMD1 block.
- iUSER_MMC_REQ / iUSER_MMC_CS / iUSER_MMC_DATA  in  1/1/8  user path.
- oUSER_MMC_BUSY  out  1  busy returned to the user path.
- oMMC_REQ  out  1  request to the transport.
- iMMC_BUSY  in  1  transport busy.
- oMMC_CS  out  1  chip select to the transport.
- oMMC_DATA  out  8  byte to the transport.
- The read path (valid/data) is wired directly to all consumers and does not pass through this block.

Behaviour:
- States: IDLE, DUMMY, CMD0_START, CMD0_WAIT, CMD1_START, CMD1_WAIT, READY, ERROR.
- Reset (iRESET_SYNC=1): state goes to IDLE; counters clear; all outputs take their IDLE values.
- IDLE/ERROR outputs: oMMC_REQ=0, oMMC_CS=1, oMMC_DATA=8'hFF, all sub-block busys=1, start pulses=0.
- Byte acceptance: a byte is accepted on any cycle with oMMC_REQ=1 and iMMC_BUSY=0.
- IDLE -> DUMMY on iINIT_START. The dummy counter clears on entry.
- DUMMY:
  - oMMC_REQ = !iMMC_BUSY, oMMC_CS=1, oMMC_DATA=8'hFF.
  - The counter increments on each accepted byte.
  - When the P_DUMMY_BYTES-th byte is accepted, go to CMD0_START on the next cycle.
- CMD0_START:
  - oCMD0_START=1 for exactly one cycle; clear the timeout counter; go to CMD0_WAIT.
- CMD0_WAIT:
  - Grant goes to CMD0. oMMC_REQ/CS/DATA = iCMD0_MMC_* combinationally (zero latency); oCMD0_MMC_BUSY = iMMC_BUSY.
  - The timeout counter increments every cycle.
  - iCMD0_END -> CMD1_START. This takes priority over a timeout in the same cycle.
  - Counter reaching P_TIMEOUT-1 without END -> ERROR, with oSUB_RESET=1 for that transition cycle.
- CMD1_START / CMD1_WAIT: identical rules with the CMD1 ports; iCMD1_END -> READY.
- READY:
  - Grant goes to the user. oMMC_* = iUSER_MMC_*; oUSER_MMC_BUSY = iMMC_BUSY.
  - iINIT_START -> DUMMY (re-initialise). The user then sees busy=1 from the next cycle.
- ERROR: holds until iINIT_START, then goes to DUMMY.
- Non-granted sources always see busy=1. Their REQ/CS/DATA are ignored.
- Start pulses occur only in the *_START states.
- iINIT_START during DUMMY or the WAIT states is ignored.
- Counter widths: dummy counter is 8 bits, timeout counter is 24 bits; neither wraps, because both clear on state entry.
- Reset mid-operation: IDLE on the next edge; no sub-reset pulse. Sub-blocks share iRESET_SYNC externally.

Decomposition:
- Shared package mmc_ctrl_pkg:
  - state encodings (3-bit);
  - constant MMC_IDLE_BYTE = 8'hFF;
  - default timeout and dummy counts.
- One natural sub-module: mmc_byte_if_mux. It holds the combinational 3-source grant mux plus busy fan-back, selected by a 2-bit grant code (NONE/CMD0/CMD1/USER).

Test Plan:
- Reset, then iINIT_START, transport never busy -> exactly 10 accepted 0xFF bytes with CS=1, then one oCMD0_START pulse; oINIT_BUSY=1 throughout.
- iMMC_BUSY toggling every other cycle during DUMMY -> still exactly 10 bytes accepted; no REQ while busy=1.
- CMD0 model ends after 7 bytes, CMD1 model ends after 3 R1 retries -> oINIT_DONE=1. A user REQ with data 0x51 then appears on oMMC_DATA the same cycle; oCMD1_MMC_BUSY=1.
- CMD1 model never ends, P_TIMEOUT=100 -> ERROR exactly 100 cycles after CMD1_START exits, oSUB_RESET pulses one cycle, oINIT_ERROR=1, CS=1.
- iCMD0_END and timeout in the same cycle -> CMD1_START, not ERROR.
- iRESET_SYNC asserted in CMD0_WAIT -> next cycle IDLE, oMMC_REQ=0, CS=1, data 0xFF; a subsequent iINIT_START restarts the dummy count from 0.
